pad_responder: RTL and testbench



---
 rtl/pad_responder.sv | 191 +++++++++++++++++++
 tb/tb_pad_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_responder.sv
// Controller-side NES/SNES serial pad emulator: answers host latch/clock with button states.
// Optional A/B turbo is compiled in when PAD_RESPONDER_TURBO_EN is defined.
module pad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pad_latch,
  input  logic        pad_clk,
  output logic        pad_data,
  input  logic        snes_mode,
  input  logic [11:0] buttons,
`ifdef PAD_RESPONDER_TURBO_EN
  input  logic [1:0]  turbo_mask,
`endif
  output logic        busy,
  output logic [4:0]  bit_index,
  output logic        read_done
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [SYNC_N-1:0] latch_sync_r;
  logic [SYNC_N-1:0] pclk_sync_r;
  logic              latch_d_r;
  logic              pclk_d_r;
  logic              latch_s;
  logic              pclk_s;
  logic              latch_fall_s;
  logic              pclk_rise_s;
  logic [15:0]       shreg_r;
  logic [4:0]        bit_index_r;
  logic [4:0]        frame_len_r;
  logic              last_bit_s;
  logic [11:0]       btn_eff_s;
  logic              pad_nx_s;
  logic              busy_nx_s;
  logic              done_nx_s;
  logic              pad_data_r;
  logic              busy_r;
  logic              read_done_r;

  // Serial order as the console sees it; all lines are active-low on the wire.
  function automatic logic [15:0] build_frame(input logic [11:0] b, input logic snes);
    logic [15:0] f;
    if (snes) begin
      f = {4'hF, ~b[11], ~b[10], ~b[8], ~b[0], ~b[7], ~b[6], ~b[5], ~b[4],
           ~b[3], ~b[2], ~b[9], ~b[1]};
    end else begin
      f = {8'h00, ~b[7:0]};
    end
    return f;
  endfunction

  // Synchronisers plus one registered copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_sync_r <= '0;
      pclk_sync_r  <= '0;
      latch_d_r    <= 1'b0;
      pclk_d_r     <= 1'b0;
    end else begin
      latch_sync_r <= {latch_sync_r[SYNC_N-2:0], pad_latch};
      pclk_sync_r  <= {pclk_sync_r[SYNC_N-2:0], pad_clk};
      latch_d_r    <= latch_sync_r[SYNC_N-1];
      pclk_d_r     <= pclk_sync_r[SYNC_N-1];
    end
  end

  assign latch_s      = latch_sync_r[SYNC_N-1];
  assign pclk_s       = pclk_sync_r[SYNC_N-1];
  assign latch_fall_s = ~latch_s & latch_d_r;
  assign pclk_rise_s  = pclk_s & ~pclk_d_r;
  assign last_bit_s   = ((bit_index_r + 5'd1) == frame_len_r);

`ifdef PAD_RESPONDER_TURBO_EN
  localparam int TCW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  logic [TCW-1:0] turbo_cnt_r;
  logic           turbo_phase_r;

  // Latch-fall counter flipping the turbo phase every TURBO_DIV frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      turbo_cnt_r   <= '0;
      turbo_phase_r <= 1'b0;
    end else if (latch_fall_s) begin
      if (turbo_cnt_r == TCW'(TURBO_DIV - 1)) begin
        turbo_cnt_r   <= '0;
        turbo_phase_r <= ~turbo_phase_r;
      end else begin
        turbo_cnt_r <= turbo_cnt_r + TCW'(1);
      end
    end
  end

  assign btn_eff_s = buttons & ~({10'b0, turbo_mask} & {12{~turbo_phase_r}});
`else
  assign btn_eff_s = buttons;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: a high latch level pre-empts everything else.
  always_comb begin
    state_nx_s = state_r;
    if (latch_s) begin
      state_nx_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx_s = ST_IDLE;
        ST_LOAD: begin
          if (latch_fall_s) state_nx_s = ST_SHIFT;
          else              state_nx_s = ST_LOAD;
        end
        ST_SHIFT: begin
          if (pclk_rise_s && last_bit_s) state_nx_s = ST_DONE;
          else                           state_nx_s = ST_SHIFT;
        end
        ST_DONE:  state_nx_s = ST_DONE;
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Output decode ahead of the output registers.
  always_comb begin
    pad_nx_s  = 1'b1;
    busy_nx_s = (state_nx_s == ST_SHIFT);
    done_nx_s = (state_r == ST_SHIFT) && (state_nx_s == ST_DONE);
    case (state_r)
      ST_IDLE:  pad_nx_s = 1'b1;
      ST_LOAD:  pad_nx_s = shreg_r[0];
      ST_SHIFT: pad_nx_s = shreg_r[0];
      ST_DONE:  pad_nx_s = 1'b0;
      default:  pad_nx_s = 1'b1;
    endcase
  end

  // Shift register, bit counter and captured frame length.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r     <= '1;
      bit_index_r <= 5'd0;
      frame_len_r <= 5'd8;
    end else if (latch_s) begin
      shreg_r     <= build_frame(btn_eff_s, snes_mode);
      bit_index_r <= 5'd0;
    end else if ((state_r == ST_LOAD) && latch_fall_s) begin
      frame_len_r <= snes_mode ? 5'd16 : 5'd8;
    end else if ((state_r == ST_SHIFT) && pclk_rise_s) begin
      shreg_r     <= {1'b0, shreg_r[15:1]};
      bit_index_r <= bit_index_r + 5'd1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_data_r  <= 1'b1;
      busy_r      <= 1'b0;
      read_done_r <= 1'b0;
    end else begin
      pad_data_r  <= pad_nx_s;
      busy_r      <= busy_nx_s;
      read_done_r <= done_nx_s;
    end
  end

  assign pad_data  = pad_data_r;
  assign busy      = busy_r;
  assign bit_index = bit_index_r;
  assign read_done = read_done_r;

endmodule

// File: tb/tb_pad_responder.sv
// Self-checking bench for pad_responder: directed frames with literal expectations,
// then randomized pin activity checked every cycle against a frame-queue model.
module tb_pad_responder;

  localparam int SYNC = 2;
  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data;
  logic        snes_mode;
  logic [11:0] buttons;
  logic        busy;
  logic [4:0]  bit_index;
  logic        read_done;
`ifdef PAD_RESPONDER_TURBO_EN
  logic [1:0]  turbo_mask;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int rd_seen     = 0;

  always #5 clk = ~clk;

  pad_responder #(.SYNC_STAGES(SYNC), .TURBO_DIV(TDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .snes_mode (snes_mode),
    .buttons   (buttons),
`ifdef PAD_RESPONDER_TURBO_EN
    .turbo_mask(turbo_mask),
`endif
    .busy      (busy),
    .bit_index (bit_index),
    .read_done (read_done)
  );

  // Model: pin histories, a queue of bits still to be read, and a coarse phase.
  bit lq[$];
  bit cq[$];
  bit m_bits[$];
  int m_phase;   // 0 idle, 1 latched, 2 reading, 3 finished
  int m_n, m_idx, m_falls;
  bit m_src, e_pad, e_busy, e_rd;
  int e_idx;

  function automatic void m_load();
    int snes_ord[12] = '{1, 9, 2, 3, 4, 5, 6, 7, 0, 8, 10, 11};
    logic [11:0] b = buttons;
`ifdef PAD_RESPONDER_TURBO_EN
    if (((m_falls / TDIV) % 2) == 0) b = b & ~{10'b0, turbo_mask};
`endif
    m_bits.delete();
    if (snes_mode) begin
      for (int i = 0; i < 12; i++) m_bits.push_back(~b[snes_ord[i]]);
      repeat (4) m_bits.push_back(1'b1);
    end else begin
      for (int i = 0; i < 8; i++) m_bits.push_back(~b[i]);
      repeat (8) m_bits.push_back(1'b0);
    end
  endfunction

  function automatic void m_reset();
    lq.delete();
    cq.delete();
    repeat (SYNC + 2) begin
      lq.push_back(1'b0);
      cq.push_back(1'b0);
    end
    m_bits.delete();
    m_phase = 0; m_idx = 0; m_n = 8; m_falls = 0;
    m_src = 1'b1; e_pad = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_idx = 0;
  endfunction

  function automatic void m_step();
    bit lvl, crise;
    lq.push_back(pad_latch); void'(lq.pop_front());
    cq.push_back(pad_clk);   void'(cq.pop_front());
    lvl   = lq[1];
    crise = cq[1] && !cq[0];
    e_pad = m_src;
    e_rd  = 1'b0;
    if (lvl) begin
      m_phase = 1; m_load(); m_idx = 0;
    end else if (m_phase == 1) begin
      m_n = snes_mode ? 16 : 8; m_falls++; m_phase = 2;
    end else if (m_phase == 2 && crise) begin
      void'(m_bits.pop_front());
      m_idx++;
      if (m_idx == m_n) begin
        m_phase = 3; e_rd = 1'b1;
      end
    end
    m_src  = (m_phase == 0) ? 1'b1 : (m_phase == 3) ? 1'b0 : m_bits[0];
    e_busy = (m_phase == 2);
    e_idx  = m_idx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) m_reset(); else m_step();
    @(negedge clk);
    chk("pad_data", pad_data, e_pad);
    chk("busy", busy, e_busy);
    chk("bit_index", bit_index, e_idx);
    chk("read_done", read_done, e_rd);
    if (read_done === 1'b1) rd_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic latch_pulse();
    pad_latch = 1'b1; hold(6);
    pad_latch = 1'b0; hold(6);
  endtask

  task automatic pclk_pulse();
    pad_clk = 1'b1; hold(5);
    pad_clk = 1'b0; hold(5);
  endtask

  task automatic clock_out(input int n, output logic [15:0] s);
    s = '0;
    for (int k = 0; k < n; k++) begin
      s[k] = pad_data;
      pclk_pulse();
    end
  endtask

  initial begin
    logic [15:0] s;
    int r0, lat;
    reset = 1'b1; pad_latch = 1'b0; pad_clk = 1'b0; snes_mode = 1'b0; buttons = 12'h000;
`ifdef PAD_RESPONDER_TURBO_EN
    turbo_mask = 2'b00;
`endif
    hold(3);
    reset = 1'b0;
    hold(20);
    chk("idle_pad", pad_data, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_idx", bit_index, 5'd0);
    chk("idle_rd_count", rd_seen, 0);

    // NES frame, A pressed
    buttons = 12'h001; snes_mode = 1'b0;
    latch_pulse();
    r0 = rd_seen;
    clock_out(8, s);
    chk("nes_stream", s[7:0], 8'hFE);
    chk("nes_rd_count", rd_seen - r0, 1);
    chk("nes_idx_end", bit_index, 5'd8);
    chk("nes_pad_after", pad_data, 1'b0);
    chk("nes_busy_after", busy, 1'b0);

    // SNES frame, B and R pressed
    buttons = 12'h802; snes_mode = 1'b1;
    latch_pulse();
    r0 = rd_seen;
    clock_out(15, s);
    chk("snes_busy_15", busy, 1'b1);
    chk("snes_idx_15", bit_index, 5'd15);
    s[15] = pad_data;
    pclk_pulse();
    chk("snes_stream", s, 16'hF7FE);
    chk("snes_busy_16", busy, 1'b0);
    chk("snes_idx_16", bit_index, 5'd16);
    chk("snes_rd_count", rd_seen - r0, 1);

    // Abort after 3 bits, then a fresh frame with new buttons
    buttons = 12'h001; snes_mode = 1'b0;
    latch_pulse();
    r0 = rd_seen;
    clock_out(3, s);
    buttons = 12'h002;
    pad_latch = 1'b1; hold(6);
    chk("abort_idx", bit_index, 5'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd_count", rd_seen - r0, 0);
    pad_latch = 1'b0; hold(6);
    clock_out(8, s);
    chk("abort_stream", s[7:0], 8'hFD);
    chk("abort_rd_total", rd_seen - r0, 1);

    // pclk during latch and after the frame is ignored
    buttons = 12'h001;
    pad_latch = 1'b1; hold(6);
    pclk_pulse(); pclk_pulse();
    chk("latchclk_idx", bit_index, 5'd0);
    pad_latch = 1'b0; hold(6);
    chk("latchclk_pad", pad_data, 1'b0);
    chk("latchclk_busy", busy, 1'b1);
    clock_out(8, s);
    chk("latchclk_stream", s[7:0], 8'hFE);
    pclk_pulse(); pclk_pulse();
    chk("done_idx_hold", bit_index, 5'd8);
    chk("done_pad_low", pad_data, 1'b0);

    // Pin-to-pad_data latency from the finished state
    buttons = 12'h000;
    pad_latch = 1'b1;
    lat = 0;
    while (pad_data !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    chk("latency", lat, SYNC + 2);
    pad_latch = 1'b0; hold(6);

    // Reset mid-frame, then a clean frame
    clock_out(3, s);
    reset = 1'b1; hold(1); reset = 1'b0; hold(6);
    chk("rst_idx", bit_index, 5'd0);
    chk("rst_pad", pad_data, 1'b1);
    buttons = 12'h001;
    latch_pulse();
    clock_out(8, s);
    chk("rst_stream", s[7:0], 8'hFE);

`ifdef PAD_RESPONDER_TURBO_EN
    reset = 1'b1; hold(2); reset = 1'b0; hold(4);
    buttons = 12'h001; snes_mode = 1'b0; turbo_mask = 2'b01;
    for (int f = 0; f < 3 * TDIV; f++) begin
      latch_pulse();
      chk("turbo_a", pad_data, (((f / TDIV) % 2) == 0) ? 1'b1 : 1'b0);
    end
    turbo_mask = 2'b00;
`endif

    // Randomized activity checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      if (pad_latch) begin
        if ($urandom_range(0, 5) == 0) pad_latch = ~pad_latch;
      end else begin
        if ($urandom_range(0, 79) == 0) pad_latch = ~pad_latch;
      end
      if ($urandom_range(0, 1) == 0) pad_clk = ~pad_clk;
      if ($urandom_range(0, 9) == 0) buttons = 12'($urandom);
      if ($urandom_range(0, 59) == 0) snes_mode = ~snes_mode;
`ifdef PAD_RESPONDER_TURBO_EN
      if ($urandom_range(0, 29) == 0) turbo_mask = 2'($urandom);
`endif
      reset = ($urandom_range(0, 799) == 0);
      cyc();
    end
    reset = 1'b0;
    chk("random_frames_seen", (rd_seen > 10) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
